// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: start/result bus plus DUT drive/sense lines; master drives start/expected/f_in, slave is the sweeper
interface truth_table_sweeper_if #(parameter int N_IN = 4);
  localparam int NV = 1 << N_IN;
  logic start;
  logic [NV-1:0] expected;
  logic f_in;
  logic [N_IN-1:0] vec_out;
  logic busy;
  logic done;
  logic [NV-1:0] table_out;
  logic [N_IN:0] mismatch_cnt;
  logic [N_IN-1:0] first_bad;
  logic first_bad_valid;
  logic match;
  modport master(output start, expected, f_in,
                 input vec_out, busy, done, table_out, mismatch_cnt, first_bad, first_bad_valid, match);
  modport slave(input start, expected, f_in,
                output vec_out, busy, done, table_out, mismatch_cnt, first_bad, first_bad_valid, match);
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps vec_out over all 2^N_IN inputs, samples f_in after SETTLE_CYC cycles and scores it against expected (ports: clk, rst, bus slave)
module truth_table_sweeper #(
  parameter int N_IN = 4,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic rst,
  truth_table_sweeper_if.slave bus
);
  localparam int NV = 1 << N_IN;
  localparam int WW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FINISH} state_t;
  state_t state, nxt;
  logic [N_IN-1:0] idx;
  logic [WW-1:0] wcnt;
  logic [NV-1:0] exp_q;
  logic last, settled, bad;
  assign last = idx == N_IN'(NV - 1);
  assign settled = wcnt == WW'(SETTLE_CYC - 1);
  assign bad = bus.f_in != exp_q[idx];
  assign bus.vec_out = idx;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE   ? (bus.start ? WAIT : IDLE) :
          state == WAIT   ? (settled ? SAMPLE : WAIT) :
          state == SAMPLE ? (last ? FINISH : WAIT) : IDLE;
  end
  always_comb begin
    bus.done = state == FINISH;
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      wcnt <= '0;
      exp_q <= '0;
      bus.busy <= 1'b0;
      bus.table_out <= '0;
      bus.mismatch_cnt <= '0;
      bus.first_bad <= '0;
      bus.first_bad_valid <= 1'b0;
      bus.match <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            idx <= '0;
            wcnt <= '0;
            exp_q <= bus.expected;
            bus.busy <= 1'b1;
            bus.table_out <= '0;
            bus.mismatch_cnt <= '0;
            bus.first_bad <= '0;
            bus.first_bad_valid <= 1'b0;
            bus.match <= 1'b0;
          end
        WAIT: wcnt <= wcnt + 1'b1;
        SAMPLE: begin
          bus.table_out[idx] <= bus.f_in;
          if (bad) bus.mismatch_cnt <= bus.mismatch_cnt + 1'b1;
          if (bad && !bus.first_bad_valid) begin
            bus.first_bad <= idx;
            bus.first_bad_valid <= 1'b1;
          end
          if (!last) begin
            idx <= idx + 1'b1;
            wcnt <= '0;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          bus.match <= bus.mismatch_cnt == '0;
        end
      endcase
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: random and directed sweeps of two sweepers (settle 1 and 3) scored against a truth-table model
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst, start;
  logic [15:0] f_tab, expd;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  truth_table_sweeper_if #(.N_IN(4)) a();
  truth_table_sweeper_if #(.N_IN(4)) b();
  assign a.start = start;
  assign b.start = start;
  assign a.expected = expd;
  assign b.expected = expd;
  assign a.f_in = f_tab[a.vec_out];
  assign b.f_in = f_tab[b.vec_out];
  truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(1)) dut_a(.clk(clk), .rst(rst), .bus(a.slave));
  truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(3)) dut_b(.clk(clk), .rst(rst), .bus(b.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zero(input string tag);
    chk({tag, " a.vec_out"}, 32'(a.vec_out), 0);
    chk({tag, " a.busy"}, 32'(a.busy), 0);
    chk({tag, " a.done"}, 32'(a.done), 0);
    chk({tag, " a.table"}, 32'(a.table_out), 0);
    chk({tag, " a.mcnt"}, 32'(a.mismatch_cnt), 0);
    chk({tag, " a.first_bad"}, 32'(a.first_bad), 0);
    chk({tag, " a.fbv"}, 32'(a.first_bad_valid), 0);
    chk({tag, " a.match"}, 32'(a.match), 0);
    chk({tag, " b.busy"}, 32'(b.busy), 0);
    chk({tag, " b.vec_out"}, 32'(b.vec_out), 0);
  endtask
  task automatic results(input string tag, input logic [15:0] ft, input logic [15:0] ex);
    int m, fb;
    m = $countones(ft ^ ex);
    fb = 0;
    for (int i = 15; i >= 0; i--) if (ft[i] != ex[i]) fb = i;
    chk({tag, " a.table"}, 32'(a.table_out), 32'(ft));
    chk({tag, " a.mcnt"}, 32'(a.mismatch_cnt), m);
    chk({tag, " a.first_bad"}, 32'(a.first_bad), fb);
    chk({tag, " a.fbv"}, 32'(a.first_bad_valid), 32'(m != 0));
    chk({tag, " a.match"}, 32'(a.match), 32'(m == 0));
    chk({tag, " a.vec_out"}, 32'(a.vec_out), 15);
    chk({tag, " a.busy"}, 32'(a.busy), 0);
    chk({tag, " b.table"}, 32'(b.table_out), 32'(ft));
    chk({tag, " b.mcnt"}, 32'(b.mismatch_cnt), m);
    chk({tag, " b.first_bad"}, 32'(b.first_bad), fb);
    chk({tag, " b.fbv"}, 32'(b.first_bad_valid), 32'(m != 0));
    chk({tag, " b.match"}, 32'(b.match), 32'(m == 0));
    chk({tag, " b.vec_out"}, 32'(b.vec_out), 15);
  endtask
  task automatic sweep(input string tag, input logic [15:0] ft, input logic [15:0] ex,
                       input int pulse_at, input int rst_at);
    int c0, rel, da, db, na, nb, drop;
    da = -1; db = -1; na = 0; nb = 0; drop = 0;
    f_tab = ft;
    expd = ex;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    expd = 16'($urandom);
    for (int n = 0; n < 70; n++) begin
      rel = cyc - c0;
      if (a.done === 1'b1) begin na++; da = rel; end
      if (b.done === 1'b1) begin nb++; db = rel; end
      if (rst_at == 0 && ((rel <= 33 && a.busy !== 1'b1) || (rel <= 65 && b.busy !== 1'b1))) drop++;
      if (rst_at != 0 && rel == rst_at + 1) zero({tag, " post-rst"});
      start = rel == pulse_at || (pulse_at != 0 && rel == 33);
      rst = rst_at != 0 && rel == rst_at;
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    if (rst_at != 0) begin
      chk({tag, " a.done count"}, 32'(na), 0);
      chk({tag, " b.done count"}, 32'(nb), 0);
    end else begin
      chk({tag, " a.done cycle"}, 32'(da), 33);
      chk({tag, " a.done count"}, 32'(na), 1);
      chk({tag, " b.done cycle"}, 32'(db), 65);
      chk({tag, " b.done count"}, 32'(nb), 1);
      chk({tag, " busy drop"}, 32'(drop), 0);
      results(tag, ft, ex);
    end
  endtask
  initial begin
    logic [15:0] ft;
    rst = 1'b1;
    start = 1'b1;
    f_tab = '0;
    expd = 16'hFFFF;
    repeat (2) @(negedge clk);
    zero("T1 rst");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    zero("T1 idle");
    sweep("T2", 16'hFF00, 16'hFF00, 0, 0);
    sweep("T3", 16'hFF00, 16'hF000, 0, 0);
    sweep("T4", 16'h0000, 16'hFFFF, 0, 0);
    sweep("T5", 16'hFF00, 16'hFF00, 10, 0);
    sweep("T6 abort", 16'hFF00, 16'hFF00, 0, 15);
    sweep("T6 rerun", 16'hFF00, 16'hFF00, 0, 0);
    for (int k = 0; k < 6; k++) begin
      ft = 16'($urandom);
      sweep("RND", ft, k[0] ? 16'($urandom) : ft ^ (16'h1 << $urandom_range(15)), 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
